lcd_cmd_sequencer: RTL and testbench
====================================

// Module: lcd_cmd_sequencer
// PURPOSE
//  Downstream of the LCD register peripheral. Turns its latched command flags into
//  HD44780 8-bit bus cycles (rs/e/data) with correct setup, pulse and hold timing.
//  Post-command waits use the shared external delay counter (en_cnt/limit_cnt/int_cnt).
//  Reports busy for software polling.
// PARAMETERS
//  T_SETUP    4      clk cycles rs/data stable before e rises
//  T_EPW      25     clk cycles e held high
//  T_HOLD     4      clk cycles rs/data held after e falls
//  W_SHORT    40     counter ticks after ordinary command/char (40 us @1 us tick)
//  W_CLEAR    1640   counter ticks after clear-display (0x01)
//  W_PWRON    15000  counter ticks power-on wait, first reset step
//  W_INIT1    4100   counter ticks after first 0x30 of reset sequence
//  W_INIT2    100    counter ticks after second 0x30 of reset sequence
// PORTS
//  clk         in   1   system clock, all state on posedge
//  rst         in   1   asynchronous, active-high reset
//  en          in   1   command strobe level; 0->1 edge launches a command
//  reset       in   1   cmd flag: full HD44780 init sequence
//  set         in   1   cmd flag: function set 0x38
//  clear       in   1   cmd flag: clear display 0x01
//  off         in   1   cmd flag: display off 0x08
//  on          in   1   cmd flag: display on, cursor off 0x0C
//  entry_mode  in   1   cmd flag: entry mode increment 0x06
//  cursor      in   1   cmd flag: set DDRAM addr 0x80|cursor_pos[6:0]
//  w_char      in   1   cmd flag: write data byte ascii_char, rs=1
//  cursor_pos  in   8   DDRAM address for cursor cmd
//  ascii_char  in   8   character code for w_char cmd
//  int_cnt     in   1   1-cycle pulse from delay counter: limit reached
//  busy        out  1   1 while a command is in progress
//  en_cnt      out  1   delay counter run enable; counter clears while low
//  limit_cnt   out  16  delay counter terminal count, ticks
//  rs          out  1   LCD register select (0 cmd, 1 data)
//  e           out  1   LCD enable strobe
//  data        out  8   LCD data bus
// BEHAVIOUR
//  - rst: state IDLE, busy=0, e=0, rs=0, data=8'h00, en_cnt=0, limit_cnt=0, step=0,
//    en_q=1 (en already high at reset release is not an edge). Reset mid-op aborts at once.
//  - Edge: launch when en=1 & en_q=0 & state==IDLE. Flags sampled that cycle, priority
//    reset>set>clear>off>on>entry_mode>cursor>w_char; only highest executes.
//    No flag set -> no-op, busy stays 0. Edges while busy dropped, not queued.
//  - busy=1 from the cycle after launch until the cycle state returns to IDLE.
//  - FSM: IDLE -> LOAD (latch byte/rs/wait) -> E_SETUP (T_SETUP) -> E_HIGH (e=1, T_EPW)
//    -> E_HOLD (T_HOLD) -> DLY (en_cnt=1) -> IDLE, or -> LOAD for next reset step.
//  - DLY: limit_cnt valid one cycle before en_cnt rises, stable while en_cnt=1. On int_cnt
//    en_cnt=0 next cycle, then advance. int_cnt outside DLY ignored. Zero limit not allowed.
//  - Waits: clear -> W_CLEAR; all others -> W_SHORT.
//  - Reset sequence (step 0..7): wait W_PWRON with no bus cycle; 0x30/W_INIT1;
//    0x30/W_INIT2; 0x30/W_SHORT; 0x38/W_SHORT; 0x08/W_SHORT; 0x01/W_CLEAR; 0x06/W_SHORT.
//  - rs/data change only in LOAD; held after E_HOLD until next LOAD. e only high in E_HIGH.
//  - Internal cycle counter 8 bits; T_* parameters must be 1..255.
// TESTING
//  - rst release, en=0: all outputs 0, busy=0; en held 1 through release -> no command.
//  - set then en 0->1 (T_EPW=25) -> rs=0, data=0x38, e high exactly 25 cycles after 4
//    setup cycles; limit_cnt=40, en_cnt=1; int_cnt pulse -> en_cnt=0 next cycle, busy=0.
//  - w_char=1, ascii_char=0x41, en 0->1 -> rs=1, data=0x41, one e pulse, limit_cnt=40.
//  - reset=1 plus w_char=1, en edge -> init only: limit_cnt 15000, then data 30,30,30,38,
//    08,01,06 with limits 4100,100,40,40,40,1640,40; 7 e pulses; busy 1 throughout.
//  - clear=1 edge then second en edge while busy -> second ignored; limit_cnt=1640.
//  - rst asserted while e=1 -> e, busy, en_cnt 0 immediately (async); next edge runs normally.

Source files
------------

// File: rtl/lcd_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_cmd_sequencer: latched LCD command flags -> HD44780 8-bit bus cycles |
// | with setup/pulse/hold timing and external delay-counter waits.           |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_cmd_sequencer #(
   parameter int T_SETUP = 4,
   parameter int T_EPW   = 25,
   parameter int T_HOLD  = 4,
   parameter int W_SHORT = 40,
   parameter int W_CLEAR = 1640,
   parameter int W_PWRON = 15000,
   parameter int W_INIT1 = 4100,
   parameter int W_INIT2 = 100
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic        reset,
   input  logic        set,
   input  logic        clear,
   input  logic        off,
   input  logic        on,
   input  logic        entry_mode,
   input  logic        cursor,
   input  logic        w_char,
   input  logic [7:0]  cursor_pos,
   input  logic [7:0]  ascii_char,
   input  logic        int_cnt,
   output logic        busy,
   output logic        en_cnt,
   output logic [15:0] limit_cnt,
   output logic        rs,
   output logic        e,
   output logic [7:0]  data
);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LOAD    = 3'd1,
      S_E_SETUP = 3'd2,
      S_E_HIGH  = 3'd3,
      S_E_HOLD  = 3'd4,
      S_DLY     = 3'd5
   } state_t;

   localparam logic [7:0]  c_setup_last = 8'(T_SETUP - 1);
   localparam logic [7:0]  c_epw_last   = 8'(T_EPW - 1);
   localparam logic [7:0]  c_hold_last  = 8'(T_HOLD - 1);
   localparam logic [15:0] c_w_short    = 16'(W_SHORT);
   localparam logic [15:0] c_w_clear    = 16'(W_CLEAR);
   localparam logic [15:0] c_w_pwron    = 16'(W_PWRON);
   localparam logic [15:0] c_w_init1    = 16'(W_INIT1);
   localparam logic [15:0] c_w_init2    = 16'(W_INIT2);
   localparam logic [2:0]  c_last_step  = 3'd7;

   state_t      state_q, state_d;
   logic [7:0]  cnt_q, cnt_d;
   logic [2:0]  step_q, step_d;
   logic        init_q, init_d;
   logic        en_q, en_d;
   logic        busy_q, busy_d;
   logic        e_q, e_d;
   logic        rs_q, rs_d;
   logic [7:0]  data_q, data_d;
   logic        en_cnt_q, en_cnt_d;
   logic [15:0] limit_q, limit_d;

   logic        cmd_valid;
   logic        cmd_init;
   logic        cmd_rs;
   logic [7:0]  cmd_byte;
   logic [15:0] cmd_wait;
   logic        launch;
   logic [2:0]  next_step;
   logic        unused_pos_msb;

   assign unused_pos_msb = cursor_pos[7];

   // Step 0 of the init sequence is a pure wait; steps 1..7 each issue one byte.
   function automatic logic [7:0] init_byte(input logic [2:0] s);
      case (s)
         3'd4:    init_byte = 8'h38;
         3'd5:    init_byte = 8'h08;
         3'd6:    init_byte = 8'h01;
         3'd7:    init_byte = 8'h06;
         default: init_byte = 8'h30;
      endcase
   endfunction

   function automatic logic [15:0] init_wait(input logic [2:0] s);
      case (s)
         3'd0:    init_wait = c_w_pwron;
         3'd1:    init_wait = c_w_init1;
         3'd2:    init_wait = c_w_init2;
         3'd6:    init_wait = c_w_clear;
         default: init_wait = c_w_short;
      endcase
   endfunction

   always_comb begin
      cmd_valid = 1'b1;
      cmd_init  = 1'b0;
      cmd_rs    = 1'b0;
      cmd_byte  = 8'h00;
      cmd_wait  = c_w_short;
      if (reset) begin
         cmd_init = 1'b1;
         cmd_wait = c_w_pwron;
      end else if (set) begin
         cmd_byte = 8'h38;
      end else if (clear) begin
         cmd_byte = 8'h01;
         cmd_wait = c_w_clear;
      end else if (off) begin
         cmd_byte = 8'h08;
      end else if (on) begin
         cmd_byte = 8'h0C;
      end else if (entry_mode) begin
         cmd_byte = 8'h06;
      end else if (cursor) begin
         cmd_byte = {1'b1, cursor_pos[6:0]};
      end else if (w_char) begin
         cmd_rs   = 1'b1;
         cmd_byte = ascii_char;
      end else begin
         cmd_valid = 1'b0;
      end
   end

   assign launch    = en && !en_q && (state_q == S_IDLE) && cmd_valid;
   assign next_step = step_q + 3'd1;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      step_d  = step_q;
      init_d  = init_q;
      rs_d    = rs_q;
      data_d  = data_q;
      limit_d = limit_q;
      en_d    = en;

      // rs/data/limit are committed on the edge into LOAD so the limit is
      // settled at least one cycle before en_cnt rises.
      case (state_q)
         S_IDLE: begin
            if (launch) begin
               state_d = S_LOAD;
               init_d  = cmd_init;
               step_d  = 3'd0;
               limit_d = cmd_wait;
               if (!cmd_init) begin
                  rs_d   = cmd_rs;
                  data_d = cmd_byte;
               end
            end
         end
         S_LOAD: begin
            if (init_q && (step_q == 3'd0)) begin
               state_d = S_DLY;
            end else begin
               state_d = S_E_SETUP;
               cnt_d   = c_setup_last;
            end
         end
         S_E_SETUP: begin
            if (cnt_q == 8'd0) begin
               state_d = S_E_HIGH;
               cnt_d   = c_epw_last;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_E_HIGH: begin
            if (cnt_q == 8'd0) begin
               state_d = S_E_HOLD;
               cnt_d   = c_hold_last;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_E_HOLD: begin
            if (cnt_q == 8'd0) begin
               state_d = S_DLY;
            end else begin
               cnt_d = cnt_q - 8'd1;
            end
         end
         S_DLY: begin
            if (int_cnt) begin
               if (init_q && (step_q != c_last_step)) begin
                  state_d = S_LOAD;
                  step_d  = next_step;
                  rs_d    = 1'b0;
                  data_d  = init_byte(next_step);
                  limit_d = init_wait(next_step);
               end else begin
                  state_d = S_IDLE;
                  init_d  = 1'b0;
                  step_d  = 3'd0;
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      busy_d   = (state_d != S_IDLE);
      e_d      = (state_d == S_E_HIGH);
      en_cnt_d = (state_d == S_DLY);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= S_IDLE;
         cnt_q    <= 8'd0;
         step_q   <= 3'd0;
         init_q   <= 1'b0;
         en_q     <= 1'b1;
         busy_q   <= 1'b0;
         e_q      <= 1'b0;
         rs_q     <= 1'b0;
         data_q   <= 8'h00;
         en_cnt_q <= 1'b0;
         limit_q  <= 16'd0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         step_q   <= step_d;
         init_q   <= init_d;
         en_q     <= en_d;
         busy_q   <= busy_d;
         e_q      <= e_d;
         rs_q     <= rs_d;
         data_q   <= data_d;
         en_cnt_q <= en_cnt_d;
         limit_q  <= limit_d;
      end
   end

   assign busy      = busy_q;
   assign e         = e_q;
   assign rs        = rs_q;
   assign data      = data_q;
   assign en_cnt    = en_cnt_q;
   assign limit_cnt = limit_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_cmd_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_cmd_sequencer: randomized bench with a step-list reference model  |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_lcd_cmd_sequencer;
   localparam int T_SETUP = 4;
   localparam int T_EPW   = 25;
   localparam int T_HOLD  = 4;
   localparam int W_SHORT = 40;
   localparam int W_CLEAR = 1640;
   localparam int W_PWRON = 15000;
   localparam int W_INIT1 = 4100;
   localparam int W_INIT2 = 100;

   localparam logic [7:0] INIT_B [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06};
   localparam int         INIT_W [7] = '{W_INIT1, W_INIT2, W_SHORT, W_SHORT, W_SHORT, W_CLEAR, W_SHORT};

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        en = 1'b0;
   logic        reset = 1'b0, set = 1'b0, clear = 1'b0, off = 1'b0, on = 1'b0;
   logic        entry_mode = 1'b0, cursor = 1'b0, w_char = 1'b0;
   logic [7:0]  cursor_pos = 8'h00, ascii_char = 8'h00;
   logic        int_cnt = 1'b0;
   logic        busy, en_cnt, rs, e;
   logic [15:0] limit_cnt;
   logic [7:0]  data;

   int vectors = 0;
   int miscompares = 0;
   int fail_prints = 0;

   lcd_cmd_sequencer dut (
      .clk(clk), .rst(rst), .en(en), .reset(reset), .set(set), .clear(clear),
      .off(off), .on(on), .entry_mode(entry_mode), .cursor(cursor), .w_char(w_char),
      .cursor_pos(cursor_pos), .ascii_char(ascii_char), .int_cnt(int_cnt),
      .busy(busy), .en_cnt(en_cnt), .limit_cnt(limit_cnt), .rs(rs), .e(e), .data(data)
   );

   always #5 clk = ~clk;

   // ---------------- reference model: list of bus steps, time-indexed ----------
   typedef struct {
      bit         bus;
      bit         rs;
      logic [7:0] d;
      int         lim;
   } step_t;

   step_t      steps[$];
   bit         m_busy = 0, m_e = 0, m_wait = 0, m_rs = 0, m_prev_en = 1;
   logic [7:0] m_data = 8'h00;
   int         m_limit = 0;
   int         m_t = 0;
   bit         spur_en = 0;

   function automatic step_t mk(bit b, bit r, logic [7:0] d, int lim);
      step_t s;
      s.bus = b; s.rs = r; s.d = d; s.lim = lim;
      return s;
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         steps.delete();
         m_busy = 0; m_t = 0; m_rs = 0; m_data = 8'h00; m_limit = 0; m_prev_en = 1;
      end else begin
         if (m_busy) begin
            if (m_wait && int_cnt) begin
               steps.delete(0);
               if (steps.size() > 0) m_t = 0;
               else m_busy = 0;
            end else begin
               m_t++;
            end
         end else if (en && !m_prev_en) begin
            steps.delete();
            if (reset) begin
               steps.push_back(mk(1'b0, 1'b0, 8'h00, W_PWRON));
               for (int i = 0; i < 7; i++) steps.push_back(mk(1'b1, 1'b0, INIT_B[i], INIT_W[i]));
            end
            else if (set)        steps.push_back(mk(1'b1, 1'b0, 8'h38, W_SHORT));
            else if (clear)      steps.push_back(mk(1'b1, 1'b0, 8'h01, W_CLEAR));
            else if (off)        steps.push_back(mk(1'b1, 1'b0, 8'h08, W_SHORT));
            else if (on)         steps.push_back(mk(1'b1, 1'b0, 8'h0C, W_SHORT));
            else if (entry_mode) steps.push_back(mk(1'b1, 1'b0, 8'h06, W_SHORT));
            else if (cursor)     steps.push_back(mk(1'b1, 1'b0, 8'h80 | (cursor_pos & 8'h7F), W_SHORT));
            else if (w_char)     steps.push_back(mk(1'b1, 1'b1, ascii_char, W_SHORT));
            if (steps.size() > 0) begin
               m_busy = 1;
               m_t = 0;
            end
         end
         if (m_busy && m_t == 0) begin
            m_limit = steps[0].lim;
            if (steps[0].bus) begin
               m_rs = steps[0].rs;
               m_data = steps[0].d;
            end
         end
         m_prev_en = en;
      end
      if (m_busy && steps.size() > 0) begin
         m_e    = steps[0].bus && (m_t >= 1 + T_SETUP) && (m_t < 1 + T_SETUP + T_EPW);
         m_wait = m_t >= (steps[0].bus ? 1 + T_SETUP + T_EPW + T_HOLD : 1);
      end else begin
         m_e = 0;
         m_wait = 0;
      end
   end

   // External delay counter: counts ticks while a wait is expected, plus optional spurious pulses.
   int dcnt = 0;
   always @(negedge clk) begin
      if (rst || !m_wait) begin
         dcnt = 0;
         int_cnt = spur_en && ($urandom_range(0, 7) == 0);
      end else begin
         dcnt++;
         int_cnt = (dcnt >= m_limit);
      end
   end

   // Per-cycle compare against the model.
   always @(negedge clk) begin
      if (!rst) begin
         vectors++;
         if (busy !== m_busy || e !== m_e || rs !== m_rs || data !== m_data ||
             en_cnt !== m_wait || limit_cnt !== 16'(m_limit)) begin
            miscompares++;
            if (fail_prints < 30) begin
               fail_prints++;
               $display("FAIL cycle @%0t: actual busy=%b e=%b rs=%b data=%h en_cnt=%b limit=%0d required busy=%b e=%b rs=%b data=%h en_cnt=%b limit=%0d",
                        $time, busy, e, rs, data, en_cnt, limit_cnt, m_busy, m_e, m_rs, m_data, m_wait, m_limit);
            end
         end
      end
   end

   // Event log for the literal pins: one entry per e pulse / per wait start.
   logic [7:0] log_d[$];
   bit         log_rs[$];
   int         log_w[$], log_gap[$], log_lim[$];
   bit         pe = 0, pb = 0, pc = 0;
   int         ew = 0, gap = 0;
   always @(negedge clk) begin
      if (rst) begin
         pe = 0; pb = 0; pc = 0; ew = 0; gap = 0;
      end else begin
         if (busy && !pb) gap = 0; else gap++;
         if (e && !pe) begin
            log_d.push_back(data); log_rs.push_back(rs); log_gap.push_back(gap); ew = 1;
         end else if (e) begin
            ew++;
         end
         if (!e && pe) log_w.push_back(ew);
         if (en_cnt && !pc) log_lim.push_back(int'(limit_cnt));
         pe = e; pb = busy; pc = en_cnt;
      end
   end

   // ---------------- stimulus ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic check(string name, int act, int exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: actual %0d required %0d", name, act, exp);
      end
   endtask

   task automatic clear_flags();
      reset = 0; set = 0; clear = 0; off = 0; on = 0; entry_mode = 0; cursor = 0; w_char = 0;
   endtask

   task automatic clear_logs();
      log_d.delete(); log_rs.delete(); log_w.delete(); log_gap.delete(); log_lim.delete();
   endtask

   task automatic pulse_en();
      en = 1;
      tick();
      en = 0;
      clear_flags();
   endtask

   task automatic wait_idle(int budget);
      int n = 0;
      while ((m_busy || busy) && n < budget) begin
         tick();
         n++;
      end
      check("wait_idle_in_budget", int'(n < budget), 1);
   endtask

   initial begin
      int n;
      // reset state, en low
      rst = 1;
      repeat (3) tick();
      rst = 0;
      tick();
      check("rst_busy", busy, 0);
      check("rst_e", e, 0);
      check("rst_rs", rs, 0);
      check("rst_data", data, 0);
      check("rst_en_cnt", en_cnt, 0);
      check("rst_limit", limit_cnt, 0);

      // en high through reset release is not an edge
      rst = 1; en = 1; set = 1;
      repeat (2) tick();
      rst = 0;
      repeat (5) tick();
      check("en_held_no_cmd", busy, 0);
      en = 0; clear_flags();
      tick();

      // function set
      clear_logs();
      set = 1;
      pulse_en();
      wait_idle(500);
      check("set_pulses", log_d.size(), 1);
      if (log_d.size() == 1) begin
         check("set_data", log_d[0], 8'h38);
         check("set_rs", log_rs[0], 0);
         check("set_gap", log_gap[0], 5);
      end
      if (log_w.size() == 1) check("set_epw", log_w[0], 25);
      else check("set_epw_count", log_w.size(), 1);
      if (log_lim.size() == 1) check("set_limit", log_lim[0], 40);
      else check("set_limit_count", log_lim.size(), 1);
      check("set_en_cnt_after", en_cnt, 0);

      // write char
      clear_logs();
      w_char = 1; ascii_char = 8'h41;
      pulse_en();
      wait_idle(500);
      check("wchar_pulses", log_d.size(), 1);
      if (log_d.size() == 1) begin
         check("wchar_data", log_d[0], 8'h41);
         check("wchar_rs", log_rs[0], 1);
      end
      if (log_lim.size() == 1) check("wchar_limit", log_lim[0], 40);

      // full init sequence, w_char lower priority
      clear_logs();
      reset = 1; w_char = 1;
      pulse_en();
      wait_idle(30000);
      begin
         logic [7:0] exp_d [7] = '{8'h30, 8'h30, 8'h30, 8'h38, 8'h08, 8'h01, 8'h06};
         int exp_l [8] = '{15000, 4100, 100, 40, 40, 40, 1640, 40};
         check("init_pulses", log_d.size(), 7);
         if (log_d.size() == 7)
            for (int i = 0; i < 7; i++) check($sformatf("init_data%0d", i), log_d[i], exp_d[i]);
         check("init_waits", log_lim.size(), 8);
         if (log_lim.size() == 8)
            for (int i = 0; i < 8; i++) check($sformatf("init_limit%0d", i), log_lim[i], exp_l[i]);
      end

      // clear, second edge while busy dropped
      clear_logs();
      clear = 1;
      pulse_en();
      repeat (50) tick();
      set = 1;
      pulse_en();
      wait_idle(3000);
      check("clear_pulses", log_d.size(), 1);
      if (log_d.size() == 1) check("clear_data", log_d[0], 8'h01);
      if (log_lim.size() == 1) check("clear_limit", log_lim[0], 1640);

      // async reset while e high
      off = 1;
      pulse_en();
      n = 0;
      while (!e && n < 100) begin tick(); n++; end
      check("e_rose", e, 1);
      repeat (3) tick();
      rst = 1;
      #1;
      check("async_e", e, 0);
      check("async_busy", busy, 0);
      check("async_en_cnt", en_cnt, 0);
      repeat (2) tick();
      rst = 0;
      tick();
      clear_logs();
      on = 1;
      pulse_en();
      wait_idle(500);
      check("after_rst_pulses", log_d.size(), 1);
      if (log_d.size() == 1) check("after_rst_data", log_d[0], 8'h0C);

      // randomized commands, edges while busy, spurious int_cnt, occasional aborts
      for (int it = 0; it < 40; it++) begin
         int abort_at;
         set        = ($urandom_range(0, 3) == 0);
         clear      = ($urandom_range(0, 7) == 0);
         off        = ($urandom_range(0, 3) == 0);
         on         = ($urandom_range(0, 3) == 0);
         entry_mode = ($urandom_range(0, 3) == 0);
         cursor     = ($urandom_range(0, 3) == 0);
         w_char     = ($urandom_range(0, 3) == 0);
         cursor_pos = 8'($urandom);
         ascii_char = 8'($urandom);
         spur_en    = ($urandom_range(0, 1) == 1);
         abort_at   = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 60) : -1;
         pulse_en();
         n = 0;
         while ((m_busy || busy) && n < 3000) begin
            if ($urandom_range(0, 31) == 0) begin
               en = ~en;
               set = $urandom_range(0, 1);
               w_char = $urandom_range(0, 1);
            end
            if (n == abort_at) begin
               rst = 1;
               tick();
               rst = 0;
            end
            tick();
            n++;
         end
         check("rand_idle_in_budget", int'(n < 3000), 1);
         en = 0; clear_flags();
         tick();
         wait_idle(3000);
         repeat ($urandom_range(0, 3)) tick();
      end
      spur_en = 0;

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
